// File: rtl/dmarb_pkg.sv
// Shared types and limits for the data-memory round-robin arbiter.
package dmarb_pkg;
  localparam int DMARB_MAX_NREQ = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } dmarb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first set bit of req at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_priority_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any
);

  always_comb begin
    int j;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any        = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NREQ requesters.
// Each grant gets one registered ACCESS cycle, then a registered Ack/RData pulse.
module data_mem_arbiter
  import dmarb_pkg::*;
#(
  parameter int W    = 8,
  parameter int A    = 8,
  parameter int NREQ = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NREQ-1:0]     Req,
  input  logic [NREQ-1:0]     We,
  input  logic [NREQ*A-1:0]   Addr,
  input  logic [NREQ*W-1:0]   WData,
  output logic [NREQ-1:0]     Gnt,
  output logic [NREQ-1:0]     Ack,
  output logic [W-1:0]        RData,
  output logic                Busy,
  output logic [A-1:0]        Mem_Addr,
  output logic [W-1:0]        Mem_DataIn,
  output logic                Mem_WriteEn,
  input  logic [W-1:0]        Mem_DataOut,
  output dmarb_state_t        Dbg_State
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  dmarb_state_t    state_q, state_d;
  logic [IW-1:0]   rr_q, owner_q, win_idx;
  logic [A-1:0]    addr_q;
  logic [W-1:0]    wdata_q, rdata_q;
  logic            we_q, win_any;
  logic [NREQ-1:0] ack_q, elig, win_oh, own_oh;

  // A requester whose Ack is showing this cycle cannot win again until the next one.
  assign elig   = Req & ~ack_q;
  assign own_oh = NREQ'(1) << owner_q;

  rr_priority_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req     (elig),
    .ptr     (rr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rr_q    <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      if (state_q == IDLE && win_any) begin
        owner_q <= win_idx;
        addr_q  <= Addr[win_idx*A +: A];
        wdata_q <= WData[win_idx*W +: W];
        we_q    <= We[win_idx];
        rr_q    <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + IW'(1);
      end
      // A write cycle also captures the word being overwritten.
      if (state_q == ACCESS) begin
        ack_q   <= own_oh;
        rdata_q <= Mem_DataOut;
      end
    end
  end

  assign Gnt         = (state_q == ACCESS) ? own_oh : '0;
  assign Busy        = (state_q == ACCESS);
  assign Ack         = ack_q;
  assign RData       = rdata_q;
  assign Mem_Addr    = (state_q == ACCESS) ? addr_q : '0;
  assign Mem_DataIn  = (state_q == ACCESS) ? wdata_q : '0;
  assign Mem_WriteEn = Reset && (state_q == ACCESS) && we_q;
  assign Dbg_State   = state_q;

  logic unused_win_oh;
  assign unused_win_oh = ^win_oh;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a 2-requester instance on a memory model
// plus a 3-requester instance for rotation order.
module tb_data_mem_arbiter;
  import dmarb_pkg::*;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  // 2-requester instance
  logic [1:0]  Req = '0, We = '0, Gnt, Ack;
  logic [15:0] Addr = '0, WData = '0;
  logic [7:0]  RData, Mem_Addr, Mem_DataIn, Mem_DataOut;
  logic        Busy, Mem_WriteEn;
  dmarb_state_t Dbg_State;
  logic [7:0]  mem [256] = '{default: 8'h00};

  data_mem_arbiter #(.W(8), .A(8), .NREQ(2)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Addr(Addr), .WData(WData),
    .Gnt(Gnt), .Ack(Ack), .RData(RData), .Busy(Busy), .Mem_Addr(Mem_Addr),
    .Mem_DataIn(Mem_DataIn), .Mem_WriteEn(Mem_WriteEn), .Mem_DataOut(Mem_DataOut),
    .Dbg_State(Dbg_State)
  );
  assign Mem_DataOut = mem[Mem_Addr];
  always @(posedge Clk) if (Mem_WriteEn) mem[Mem_Addr] <= Mem_DataIn;

  // 3-requester instance
  logic [2:0]  Req3 = '0, We3 = '0, Gnt3, Ack3;
  logic [23:0] Addr3 = '0, WData3 = '0;
  logic [7:0]  RData3, Mem_Addr3, Mem_DataIn3, Mem_DataOut3;
  logic        Busy3, Mem_WriteEn3;
  dmarb_state_t Dbg_State3;
  logic [7:0]  mem3 [256] = '{default: 8'h00};

  data_mem_arbiter #(.W(8), .A(8), .NREQ(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Req(Req3), .We(We3), .Addr(Addr3), .WData(WData3),
    .Gnt(Gnt3), .Ack(Ack3), .RData(RData3), .Busy(Busy3), .Mem_Addr(Mem_Addr3),
    .Mem_DataIn(Mem_DataIn3), .Mem_WriteEn(Mem_WriteEn3), .Mem_DataOut(Mem_DataOut3),
    .Dbg_State(Dbg_State3)
  );
  assign Mem_DataOut3 = mem3[Mem_Addr3];
  always @(posedge Clk) if (Mem_WriteEn3) mem3[Mem_Addr3] <= Mem_DataIn3;

  // scoreboard counters
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are checked at the falling edge
  task automatic step();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    step();
  endtask

  // One isolated access by requester idx; starts and ends idle and unmasked.
  task automatic single(input int idx, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] rd_exp);
    logic [1:0] oh;
    oh = 2'(1 << idx);
    Req[idx] = 1'b1;
    We[idx]  = we;
    Addr[idx*8 +: 8]  = addr;
    WData[idx*8 +: 8] = wd;
    step();
    chk("acc_gnt", 32'(Gnt), 32'(oh));
    chk("acc_busy", 32'(Busy), 32'd1);
    chk("acc_we", 32'(Mem_WriteEn), 32'(we));
    chk("acc_addr", 32'(Mem_Addr), 32'(addr));
    if (we) chk("acc_din", 32'(Mem_DataIn), 32'(wd));
    Req[idx] = 1'b0;
    step();
    chk("ack", 32'(Ack), 32'(oh));
    chk("ack_rdata", 32'(RData), 32'(rd_exp));
    chk("ack_gnt0", 32'(Gnt), 32'd0);
    step();
  endtask

  logic [1:0] gnt_t3 [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] ack_t3 [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0] gnt_t4 [9] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
  logic [1:0] ack_t4 [9] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};

  initial begin
    step();
    step();
    chk("rst_gnt", 32'(Gnt), 32'd0);
    chk("rst_ack", 32'(Ack), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_rdata", 32'(RData), 32'd0);
    chk("rst_state", 32'(Dbg_State), 32'(IDLE));
    chk("rst_memwe", 32'(Mem_WriteEn), 32'd0);
    Reset = 1'b1;
    step();

    // write then read back; write returns the old word
    single(0, 1'b1, 8'h10, 8'hA5, 8'h00);
    single(0, 1'b0, 8'h10, 8'h00, 8'hA5);
    single(1, 1'b1, 8'hFF, 8'h77, 8'h00);
    single(0, 1'b0, 8'h10, 8'h00, 8'hA5);

    // reset asserted during a write's ACCESS cycle
    Req[0] = 1'b1; We[0] = 1'b1; Addr[7:0] = 8'hFF; WData[7:0] = 8'h3C;
    step();
    chk("r5_we_before", 32'(Mem_WriteEn), 32'd1);
    Reset = 1'b0;
    Req = '0; We = '0;
    #1;
    chk("r5_memwe", 32'(Mem_WriteEn), 32'd0);
    chk("r5_gnt", 32'(Gnt), 32'd0);
    chk("r5_busy", 32'(Busy), 32'd0);
    chk("r5_ack", 32'(Ack), 32'd0);
    chk("r5_rdata", 32'(RData), 32'd0);
    step();
    chk("r5_ack_hold", 32'(Ack), 32'd0);
    Reset = 1'b1;
    step();
    chk("r5_ack_after", 32'(Ack), 32'd0);
    chk("r5_word", 32'(mem[8'hFF]), 32'h77);
    single(0, 1'b0, 8'hFF, 8'h00, 8'h77);

    // both requesters held: strict alternation starting at 0
    do_reset();
    Req = 2'b11; We = 2'b00; Addr = {8'hFF, 8'h10};
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("rot_gnt", 32'(Gnt), 32'(gnt_t3[c-1]));
      chk("rot_ack", 32'(Ack), 32'(ack_t3[c-1]));
      if (ack_t3[c-1] != 2'b00)
        chk("rot_rdata", 32'(RData), (ack_t3[c-1] == 2'b01) ? 32'hA5 : 32'h77);
      if (c == 7) Req = 2'b00;
    end
    step();
    chk("rot_idle_busy", 32'(Busy), 32'd0);
    chk("rot_idle_gnt", 32'(Gnt), 32'd0);

    // one requester held alone: one access every 3 cycles
    do_reset();
    Req = 2'b01; We = 2'b00; Addr = {8'h00, 8'h10};
    for (int c = 1; c <= 9; c++) begin
      step();
      chk("solo_gnt", 32'(Gnt), 32'(gnt_t4[c-1]));
      chk("solo_ack", 32'(Ack), 32'(ack_t4[c-1]));
      if (c == 7) Req = 2'b00;
    end
    chk("solo_busy", 32'(Busy), 32'd0);

    // three requesters: after 1 is served, pointer sits at 2, so 2 beats 0
    do_reset();
    Req3 = 3'b010;
    step();
    chk("n3_gnt1", 32'(Gnt3), 32'b010);
    Req3 = 3'b000;
    step();
    chk("n3_ack1", 32'(Ack3), 32'b010);
    chk("n3_gnt_none", 32'(Gnt3), 32'b000);
    Req3 = 3'b101;
    step();
    chk("n3_gnt2", 32'(Gnt3), 32'b100);
    step();
    chk("n3_ack2", 32'(Ack3), 32'b100);
    chk("n3_gnt_gap", 32'(Gnt3), 32'b000);
    step();
    chk("n3_gnt0", 32'(Gnt3), 32'b001);
    Req3 = 3'b000;
    step();
    chk("n3_ack0", 32'(Ack3), 32'b001);
    step();
    chk("n3_idle", 32'(Busy3), 32'd0);
    chk("n3_idle_gnt", 32'(Gnt3), 32'b000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
